// File: rtl/elevator_pkg.sv
// Shared controller types for the elevator subsystem.
package elevator_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } direction_t;

    typedef enum logic {
        GO   = 1'b0,
        STOP = 1'b1
    } engine_op_t;

    typedef enum logic {
        CLOSE = 1'b0,
        OPEN  = 1'b1
    } doors_op_t;

endpackage

// File: rtl/request_scheduler.sv
// Request scheduler: latches per-floor button presses into a pending bitmap and
// presents one SCAN-ordered target floor (one-hot) to the elevator controller.
module request_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS  = 5,
    parameter bit          ENROUTE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] buttonPress,
    input  logic [FLOORS-1:0] currentFloor,
    input  direction_t        direction,
    input  engine_op_t        engineOp,
    input  doors_op_t         doorsOp,
    output logic [FLOORS-1:0] requestFloor,
    output logic [FLOORS-1:0] pendingMask,
    output logic              floorErr
);

    localparam int unsigned IDX_W = (FLOORS > 1) ? $clog2(FLOORS) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state;

    logic               cur_onehot;
    logic [FLOORS-1:0]  service;
    logic [FLOORS-1:0]  pending_next;
    logic [IDX_W-1:0]   cur_idx;
    logic [IDX_W-1:0]   tgt_idx;
    logic               above_hit;
    logic [IDX_W-1:0]   above_idx;
    logic               below_hit;
    logic [IDX_W-1:0]   below_idx;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [FLOORS-1:0]  sel_onehot;
    logic               nearer;
    logic               retarget;

    // Car position sanity and service detection; a corrupt position never serves.
    always_comb begin
        cur_onehot   = (currentFloor != '0) &&
                       ((currentFloor & (currentFloor - FLOORS'(1))) == '0);
        service      = (cur_onehot && engineOp == STOP && doorsOp == OPEN) ? currentFloor : '0;
        pending_next = (pendingMask | buttonPress) & ~service;
    end

    // Encode car and target positions to indices (inputs assumed one-hot when used).
    always_comb begin
        cur_idx = '0;
        tgt_idx = '0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (currentFloor[i]) cur_idx = cur_idx | IDX_W'(i);
            if (requestFloor[i]) tgt_idx = tgt_idx | IDX_W'(i);
        end
    end

    // Nearest pending floor above (lowest) and below (highest) the car.
    always_comb begin
        above_hit = 1'b0;
        above_idx = '0;
        below_hit = 1'b0;
        below_idx = '0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (pendingMask[i] && (IDX_W'(i) > cur_idx) && !above_hit) begin
                above_hit = 1'b1;
                above_idx = IDX_W'(i);
            end
            if (pendingMask[i] && (IDX_W'(i) < cur_idx)) begin
                below_hit = 1'b1;
                below_idx = IDX_W'(i);
            end
        end
    end

    // SCAN selection: current floor, then ahead in direction, then nearest behind.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        if (cur_onehot) begin
            if ((pendingMask & currentFloor) != '0) begin
                sel_valid = 1'b1;
                sel_idx   = cur_idx;
            end else if (direction == UP) begin
                if (above_hit) begin
                    sel_valid = 1'b1;
                    sel_idx   = above_idx;
                end else if (below_hit) begin
                    sel_valid = 1'b1;
                    sel_idx   = below_idx;
                end
            end else begin
                if (below_hit) begin
                    sel_valid = 1'b1;
                    sel_idx   = below_idx;
                end else if (above_hit) begin
                    sel_valid = 1'b1;
                    sel_idx   = above_idx;
                end
            end
        end
        sel_onehot = sel_valid ? (FLOORS'(1) << sel_idx) : '0;
    end

    // En-route retarget: only while stopped with doors not open, and only strictly nearer.
    always_comb begin
        if (direction == UP) begin
            nearer = (sel_idx >= cur_idx) && (sel_idx < tgt_idx);
        end else begin
            nearer = (sel_idx <= cur_idx) && (sel_idx > tgt_idx);
        end
        retarget = ENROUTE && (engineOp == STOP) && (doorsOp != OPEN) && sel_valid && nearer;
    end

    // Pending bitmap, sticky position error and the IDLE/HOLD target register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            requestFloor <= '0;
            pendingMask  <= '0;
            floorErr     <= 1'b0;
        end else begin
            pendingMask <= pending_next;
            if (!cur_onehot) begin
                floorErr <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if ((pendingMask != '0) && sel_valid) begin
                        requestFloor <= sel_onehot;
                        state        <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if ((service & requestFloor) != '0) begin
                        requestFloor <= '0;
                        state        <= S_IDLE;
                    end else if (retarget) begin
                        requestFloor <= sel_onehot;
                    end
                end
                default: begin
                    requestFloor <= '0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule
